// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and constants for the pipeline controller
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        BUS_WAIT = 2'd2
    } state_e;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int BUS_TMO_DEF = 255;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard/redirect inputs from the pipeline and stall/flush controls back to it
interface pipe_ctrl_if #(parameter int AW = 32);
    logic          jump_flag_i;
    logic [AW-1:0] jump_addr_i;
    logic          ld_hazard_i;
    logic          div_start_i;
    logic          div_done_i;
    logic          bus_req_i;
    logic          bus_gnt_i;
    logic          pc_stall_o;
    logic          if_id_stall_o;
    logic          id_ex_stall_o;
    logic          ex_mem_stall_o;
    logic          if_id_flush_o;
    logic          id_ex_flush_o;
    logic          jump_flag_o;
    logic [AW-1:0] jump_addr_o;
    logic          bus_tmo_o;
    modport slave (
        input  jump_flag_i, jump_addr_i, ld_hazard_i, div_start_i, div_done_i, bus_req_i, bus_gnt_i,
        output pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
        output if_id_flush_o, id_ex_flush_o, jump_flag_o, jump_addr_o, bus_tmo_o
    );
    modport master (
        output jump_flag_i, jump_addr_i, ld_hazard_i, div_start_i, div_done_i, bus_req_i, bus_gnt_i,
        input  pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
        input  if_id_flush_o, id_ex_flush_o, jump_flag_o, jump_addr_o, bus_tmo_o
    );
endinterface

// File: rtl/pipe_ctrl_stall_cnt.sv
// stall_cnt: saturating wait counter with clear and a flag one count before the limit
module stall_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    logic [W-1:0] cnt_q, cnt_d;
    // clear wins over enable; count stops at MAX
    always_comb begin
        cnt_d = clr_i ? '0 : (en_i && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;
    end
    // counter register
    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
    assign tc_o = cnt_q == MAX - 1'b1;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush/redirect controller for divide, load-use and bus waits
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int AW      = 32,
    parameter int BUS_TMO = BUS_TMO_DEF
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);
    localparam logic [7:0] TMO8 = BUS_TMO[7:0];
    state_e        state_q, state_d;
    logic          guard_q, guard_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic          tmo_q, tmo_d;
    logic          run, dwait, bwait, bus_st, jmp, div, ld, div_done, bus_exit, tc;
    logic          pc_st, ifid_st, idex_st, exmem_st, ifid_fl, idex_fl;

    stall_cnt #(.W(8), .MAX(TMO8)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr_i(run),
        .en_i (bwait),
        .tc_o (tc)
    );

    // event decode: bus wait beats jump beats divide beats load-use; a parked jump counts as a jump
    always_comb begin
        run      = state_q == RUN;
        dwait    = state_q == DIV_WAIT;
        bwait    = state_q == BUS_WAIT;
        bus_st   = bus.bus_req_i & ~bus.bus_gnt_i;
        jmp      = run & ~bus_st & (pend_q | bus.jump_flag_i);
        div      = run & ~bus_st & ~jmp & bus.div_start_i;
        ld       = run & ~bus_st & ~jmp & ~bus.div_start_i & bus.ld_hazard_i & ~guard_q;
        div_done = bus.div_done_i & ~bus.div_start_i;
        bus_exit = bus.bus_gnt_i | tc;
        ifid_fl  = jmp;
        idex_fl  = jmp | ld;
        pc_st    = (run & (bus_st | div | ld)) | (dwait & ~div_done) | (bwait & ~bus_exit);
        ifid_st  = pc_st & ~ifid_fl;
        idex_st  = ((run & (bus_st | div)) | (dwait & ~div_done) | (bwait & ~bus_exit)) & ~idex_fl;
        exmem_st = (run & bus_st) | (bwait & ~bus_exit);
    end

    // next state, one-bubble guard, jump parking during bus waits and timeout pulse
    always_comb begin
        state_d     = run   ? (bus_st ? BUS_WAIT : div ? DIV_WAIT : RUN) :
                      dwait ? (div_done ? RUN : DIV_WAIT) :
                      bwait ? (bus_exit ? RUN : BUS_WAIT) : RUN;
        guard_d     = ld;
        pend_d      = bwait ? (pend_q | bus.jump_flag_i) : (pend_q & ~jmp);
        pend_addr_d = (bwait & ~pend_q & bus.jump_flag_i) ? bus.jump_addr_i : pend_addr_q;
        tmo_d       = bwait & ~bus.bus_gnt_i & tc;
    end

    // controller state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            guard_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            guard_q     <= guard_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            tmo_q       <= tmo_d;
        end
    end

    assign bus.pc_stall_o     = rst & pc_st;
    assign bus.if_id_stall_o  = rst & ifid_st;
    assign bus.id_ex_stall_o  = rst & idex_st;
    assign bus.ex_mem_stall_o = rst & exmem_st;
    assign bus.if_id_flush_o  = rst & ifid_fl;
    assign bus.id_ex_flush_o  = rst & idex_fl;
    assign bus.jump_flag_o    = rst & jmp;
    assign bus.jump_addr_o    = (rst & jmp) ? (pend_q ? pend_addr_q : bus.jump_addr_i) : '0;
    assign bus.bus_tmo_o      = rst & tmo_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for the pipeline controller
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.AW(32)) bus ();
    pipe_ctrl #(.AW(32), .BUS_TMO(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    // flag byte: {pc, if_id_st, id_ex_st, ex_mem_st, if_id_fl, id_ex_fl, jump, tmo}
    localparam logic [7:0] NONE = 8'h00;
    localparam logic [7:0] S3   = 8'hE0;
    localparam logic [7:0] S4   = 8'hF0;
    localparam logic [7:0] JMP  = 8'h0E;
    localparam logic [7:0] LD   = 8'hC4;
    localparam logic [7:0] TMO  = 8'h01;

    int n_checks = 0;
    int n_fail = 0;
    string tag_q[$];
    logic [39:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got flags=%b addr=%h, expected flags=%b addr=%h",
                     tag, got[39:32], got[31:0], exp[39:32], exp[31:0]);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic jf, input logic [31:0] ja,
                        input logic ld, input logic ds, input logic dd, input logic br, input logic bg,
                        input logic [7:0] f, input logic [31:0] a);
        @(posedge clk);
        #1;
        rst             = r;
        bus.jump_flag_i = jf;
        bus.jump_addr_i = ja;
        bus.ld_hazard_i = ld;
        bus.div_start_i = ds;
        bus.div_done_i  = dd;
        bus.bus_req_i   = br;
        bus.bus_gnt_i   = bg;
        tag_q.push_back(tag);
        exp_q.push_back({f, a});
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0)
            check_eq(tag_q.pop_front(),
                     {bus.pc_stall_o, bus.if_id_stall_o, bus.id_ex_stall_o, bus.ex_mem_stall_o,
                      bus.if_id_flush_o, bus.id_ex_flush_o, bus.jump_flag_o, bus.bus_tmo_o,
                      bus.jump_addr_o},
                     exp_q.pop_front());
    end

    initial begin
        bus.jump_flag_i = 1'b0;
        bus.jump_addr_i = '0;
        bus.ld_hazard_i = 1'b0;
        bus.div_start_i = 1'b0;
        bus.div_done_i  = 1'b0;
        bus.bus_req_i   = 1'b0;
        bus.bus_gnt_i   = 1'b0;
        //   tag            rst jf  addr        ld ds dd br bg  flags addr
        step("rst_jump",    0, 1, 32'h0000_0100, 0, 0, 0, 0, 0, NONE, 32'h0);
        step("rst_idle",    0, 0, 32'h0,         0, 0, 0, 0, 0, NONE, 32'h0);
        step("run_idle",    1, 0, 32'h0,         0, 0, 0, 0, 0, NONE, 32'h0);
        step("jump_100",    1, 1, 32'h0000_0100, 0, 0, 0, 0, 0, JMP,  32'h0000_0100);
        step("after_jump",  1, 0, 32'h0,         0, 0, 0, 0, 0, NONE, 32'h0);
        step("ld_first",    1, 0, 32'h0,         1, 0, 0, 0, 0, LD,   32'h0);
        step("ld_second",   1, 0, 32'h0,         1, 0, 0, 0, 0, NONE, 32'h0);
        step("ld_gap",      1, 0, 32'h0,         0, 0, 0, 0, 0, NONE, 32'h0);
        step("ld_again",    1, 0, 32'h0,         1, 0, 0, 0, 0, LD,   32'h0);
        step("ld_done",     1, 0, 32'h0,         0, 0, 0, 0, 0, NONE, 32'h0);
        step("prio_jump",   1, 1, 32'h0000_0abc, 1, 1, 0, 0, 0, JMP,  32'h0000_0abc);
        step("prio_after",  1, 0, 32'h0,         0, 0, 0, 0, 0, NONE, 32'h0);
        step("div_start",   1, 0, 32'h0,         0, 1, 0, 0, 0, S3,   32'h0);
        step("div_wait1",   1, 0, 32'h0,         0, 0, 0, 0, 0, S3,   32'h0);
        step("div_ign_jmp", 1, 1, 32'h0000_0044, 0, 0, 0, 0, 0, S3,   32'h0);
        step("div_dn_st",   1, 0, 32'h0,         0, 1, 1, 0, 0, S3,   32'h0);
        step("div_wait4",   1, 0, 32'h0,         0, 0, 0, 0, 0, S3,   32'h0);
        step("div_done",    1, 0, 32'h0,         0, 0, 1, 0, 0, NONE, 32'h0);
        step("div_run",     1, 0, 32'h0,         0, 0, 0, 0, 0, NONE, 32'h0);
        step("bus_gnt_now", 1, 0, 32'h0,         0, 0, 0, 1, 1, NONE, 32'h0);
        step("tmo_c0",      1, 0, 32'h0,         0, 0, 0, 1, 0, S4,   32'h0);
        step("tmo_c1",      1, 0, 32'h0,         0, 0, 0, 1, 0, S4,   32'h0);
        step("tmo_c2",      1, 0, 32'h0,         0, 0, 0, 1, 0, S4,   32'h0);
        step("tmo_c3",      1, 0, 32'h0,         0, 0, 0, 1, 0, S4,   32'h0);
        step("tmo_term",    1, 0, 32'h0,         0, 0, 0, 1, 0, NONE, 32'h0);
        step("tmo_pulse",   1, 0, 32'h0,         0, 0, 0, 0, 0, TMO,  32'h0);
        step("tmo_single",  1, 0, 32'h0,         0, 0, 0, 0, 0, NONE, 32'h0);
        step("bw_enter",    1, 1, 32'h0000_0999, 0, 0, 0, 1, 0, S4,   32'h0);
        step("bw_jmp200",   1, 1, 32'h0000_0200, 0, 0, 0, 1, 0, S4,   32'h0);
        step("bw_jmp300",   1, 1, 32'h0000_0300, 0, 0, 0, 1, 0, S4,   32'h0);
        step("bw_wait",     1, 0, 32'h0,         0, 0, 0, 1, 0, S4,   32'h0);
        step("bw_grant",    1, 0, 32'h0,         0, 0, 0, 1, 1, NONE, 32'h0);
        step("bw_issue",    1, 0, 32'h0,         0, 0, 0, 0, 0, JMP,  32'h0000_0200);
        step("bw_after",    1, 0, 32'h0,         0, 0, 0, 0, 0, NONE, 32'h0);
        step("rd_start",    1, 0, 32'h0,         0, 1, 0, 0, 0, S3,   32'h0);
        step("rd_wait",     1, 0, 32'h0,         0, 0, 0, 0, 0, S3,   32'h0);
        step("rd_rst",      0, 0, 32'h0,         0, 0, 0, 0, 0, NONE, 32'h0);
        step("rd_run",      1, 0, 32'h0,         0, 0, 0, 0, 0, NONE, 32'h0);
        step("rd_run2",     1, 0, 32'h0,         0, 0, 0, 0, 0, NONE, 32'h0);
        step("rb_enter",    1, 0, 32'h0,         0, 0, 0, 1, 0, S4,   32'h0);
        step("rb_jmp",      1, 1, 32'h0000_0055, 0, 0, 0, 1, 0, S4,   32'h0);
        step("rb_rst",      0, 1, 32'h0000_0055, 0, 0, 0, 1, 0, NONE, 32'h0);
        step("rb_run",      1, 0, 32'h0,         0, 0, 0, 0, 0, NONE, 32'h0);
        step("rb_run2",     1, 0, 32'h0,         0, 0, 0, 0, 0, NONE, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter AW, default 32, program-counter/jump-address width.
REQ-002 SHALL have parameter BUS_TMO, default 255, bus-wait timeout in cycles (8-bit counter).
REQ-003 SHALL have port clk  input  1  sole clock, all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port jump_flag_i  input  1  EX stage requests redirect.
REQ-006 SHALL have port jump_addr_i  input  AW  redirect target.
REQ-007 SHALL have port ld_hazard_i  input  1  load-use hazard detected in ID.
REQ-008 SHALL have port div_start_i  input  1  multi-cycle divide issued in EX.
REQ-009 SHALL have port div_done_i  input  1  divide result valid.
REQ-010 SHALL have port bus_req_i  input  1  MEM stage bus access pending.
REQ-011 SHALL have port bus_gnt_i  input  1  bus access complete.
REQ-012 SHALL have port pc_stall_o  output  1  PC holds current value.
REQ-013 SHALL have port if_id_stall_o / id_ex_stall_o / ex_mem_stall_o  output  1 each  stage register keeps its data.
REQ-014 SHALL have port if_id_flush_o / id_ex_flush_o  output  1 each  stage register loads its reset/NOP value (hold_flag input of the stage flop).
REQ-015 SHALL have port jump_flag_o  output  1  and jump_addr_o  output  AW  redirect to PC.
REQ-016 SHALL have port bus_tmo_o  output  1  one-cycle pulse on bus timeout.

Function
REQ-017 SHALL implement FSM states RUN, DIV_WAIT, BUS_WAIT; all outputs are combinational decodes of state and inputs, except bus_tmo_o and the pending-jump register.
REQ-018 RUN priority SHALL be bus_req_i&!bus_gnt_i > jump_flag_i > div_start_i > ld_hazard_i.
REQ-019 RUN, jump_flag_i=1: same cycle jump_flag_o=1, jump_addr_o=jump_addr_i, if_id_flush_o=id_ex_flush_o=1; stay RUN.
REQ-020 RUN, ld_hazard_i=1 (no higher event): pc_stall_o=if_id_stall_o=1, id_ex_flush_o=1 for that cycle; a second consecutive ld_hazard_i cycle SHALL be ignored (one-bubble guard flop).
REQ-021 RUN, div_start_i=1: next state DIV_WAIT; in DIV_WAIT pc, if_id, id_ex stalls=1 every cycle.
REQ-022 DIV_WAIT, div_done_i=1: stalls deasserted that same cycle, next state RUN; div_done_i and div_start_i in same cycle → stay DIV_WAIT.
REQ-023 RUN, bus_req_i=1 & bus_gnt_i=0: all four stalls=1, next state BUS_WAIT, wait counter cleared; bus_req_i with bus_gnt_i=1 in same cycle → no stall.
REQ-024 BUS_WAIT: all four stalls=1 until bus_gnt_i=1 (stalls drop that cycle, next RUN); counter increments each waiting cycle, saturating at BUS_TMO.
REQ-025 BUS_WAIT, counter==BUS_TMO-1 without grant: bus_tmo_o=1 next cycle for exactly one cycle, next state RUN.
REQ-026 jump_flag_i in BUS_WAIT SHALL be latched (first wins, address captured) and issued per REQ-019 in the first RUN cycle; DIV_WAIT ignores jump_flag_i.
REQ-027 Flush SHALL override stall on the same stage register.

Reset
REQ-028 rst=0 at a clock edge: state=RUN, counter=0, guard=0, pending jump cleared, bus_tmo_o=0; all other outputs 0 while rst=0, including mid-DIV_WAIT/BUS_WAIT.

Structure
REQ-029 Shared package SHALL hold the state encoding, NOP constant 32'h00000013 and the BUS_TMO default.
REQ-030 Wait counter SHALL be sub-module stall_cnt (clear, enable, saturate, terminal-count flag).

Verification
REQ-031 jump_flag_i=1, addr 0x100 in RUN → same cycle jump_flag_o=1, jump_addr_o=0x100, both flushes=1.
REQ-032 ld_hazard_i high 2 cycles → exactly one cycle pc_stall_o=1, id_ex_flush_o=1.
REQ-033 div_start_i, div_done_i 5 cycles later → pc/if_id/id_ex stalls high 5 cycles, RUN after.
REQ-034 bus_req_i held, no grant, BUS_TMO=4 → stalls 4 cycles, bus_tmo_o single pulse, RUN.
REQ-035 jump 0x200 during BUS_WAIT, grant 3 cycles later → jump_flag_o=1, addr 0x200 first RUN cycle.
REQ-036 rst=0 mid-DIV_WAIT → next cycle state RUN, all outputs 0.
